mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
Two-port master for the 16-bit memory bus: arbitrates between the CPU instruction-fetch port (read-only) and data port (read/write). Sits directly upstream of simulated_memory and drives its read/write/addr/data_out, consuming data_in/ack. Converts level-held CPU requests into a one-cycle memory strobe, waits for the memory ack, and returns a one-cycle port ack with captured read data.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data word width
TIMEOUT_CYCLES, 15, max cycles in WAIT before abort (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
i_req  in  1  instruction fetch request, level; held until i_ack
i_addr  in  ADDR_W  fetch address, stable while i_req
i_ack  out  1  one-cycle completion pulse, instruction port
i_data  out  DATA_W  fetched word, valid when i_ack, held until next i-port completion
d_req  in  1  data request, level; held until d_ack
d_we  in  1  1 = write, 0 = read; stable while d_req
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_ack  out  1  one-cycle completion pulse, data port
d_rdata  out  DATA_W  read data, valid when d_ack after a read; held otherwise
bus_err  out  1  high with the ack of an aborted transaction; 0 without macro
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_data_out  out  DATA_W  memory write data
mem_data_in  in  DATA_W  memory read data
mem_ack  in  1  memory ack (registered by memory, high the cycle after strobe)

Behaviour:
- Reset (async): all outputs 0, state IDLE, last_grant = instruction (so data port wins first tie).
- States: IDLE, ISSUE, WAIT, DONE. All outputs registered.
- IDLE: no req -> stay. Any req -> grant (single requester wins; both -> port not equal to last_grant), latch addr/wdata/we into mem_addr/mem_data_out, set mem_read (i-port or d_we=0) or mem_write (d_we=1), update last_grant, -> ISSUE.
- ISSUE: strobe high exactly this one cycle; clear strobes at edge, -> WAIT. mem_ack ignored in ISSUE.
- WAIT: strobes 0, mem_addr/mem_data_out held. mem_ack=1 -> capture mem_data_in into i_data or d_rdata (reads only; writes leave d_rdata unchanged), assert granted port ack, -> DONE.
- DONE: granted ack high for this cycle only; no new grant this cycle (requester's req still high here must not re-issue). -> IDLE.
- Latency: req sampled at edge 0 -> port ack high in cycle 3; back-to-back throughput one transaction per 4 cycles.
- Never both mem_read and mem_write; never both acks.
- Port req deasserted mid-transaction: transaction still completes and acks (protocol violation tolerated, no hang).
- reset mid-operation: immediate abort to IDLE, strobes/acks cleared; no ack for in-flight request.
- Ports with req held continuously under contention alternate grants: d, i, d, i ...

Optional Feature:
MEM_ARB_TIMEOUT_EN: WAIT contains a cycle counter cleared on entry. If TIMEOUT_CYCLES cycles elapse in WAIT without mem_ack, -> DONE with port ack, bus_err=1, read data forced to all-ones, memory not written-back. A late mem_ack arriving in DONE/IDLE is ignored. Without macro: no counter, WAIT waits indefinitely, bus_err tied 0.

Decomposition:
- Shared package/include mem_bus_defs: state encodings (IDLE, ISSUE, WAIT, DONE), port-id constants (PORT_I=0, PORT_D=1), bus width constants.
- Sub-module mem_arb_timer: loadable down-counter with expiry flag, instantiated only under MEM_ARB_TIMEOUT_EN. Arbitration stays inline.

Test Plan:
- i_req=1, i_addr=0x0010, memory[0x0010]=0xBEEF -> mem_read high exactly one cycle with mem_addr=0x0010; i_ack pulse 3 cycles after req, i_data=0xBEEF.
- d_req=1, d_we=1, d_addr=0x0020, d_wdata=0x1234 -> one-cycle mem_write, d_ack in cycle 3; subsequent d read of 0x0020 returns d_rdata=0x1234, d_rdata unchanged by the write.
- i_req and d_req both asserted from reset and held -> grant order d, i, d, i; acks every 4 cycles alternating ports; no double strobe.
- Requester keeps req high during DONE cycle -> no strobe issued in DONE; next strobe starts only after IDLE.
- reset pulsed during WAIT -> all outputs 0 asynchronously, no ack; fresh request afterwards completes normally.
- With MEM_ARB_TIMEOUT_EN, memory ack stuck 0, TIMEOUT_CYCLES=4 -> d_ack and bus_err high together after 4 WAIT cycles, d_rdata=0xFFFF; without macro, bench confirms no ack after 100 cycles.

Source files
------------

// File: rtl/mem_bus_defs.sv
// mem_bus_defs: shared definitions for the two-port memory bus arbiter.
//   - Bus width defaults (16-bit address, 16-bit data).
//   - FSM state encodings: IDLE, ISSUE, WAIT, DONE.
//   - Port identifiers: PORT_I (instruction fetch) = 0, PORT_D (data) = 1.
//   - pick_data_port(): grant decision when leaving IDLE.
package mem_bus_defs;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // A lone requester always wins. On a tie, the port that did not
  // receive the previous grant wins, so held requests alternate.
  function automatic logic pick_data_port(input logic i_req,
                                          input logic d_req,
                                          input logic last_grant);
    return d_req && (!i_req || (last_grant == PORT_I));
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: loadable down-counter with an expiry flag.
// It is used by mem_bus_arbiter only when MEM_ARB_TIMEOUT_EN is defined.
//   clock      : rising-edge clock
//   reset      : asynchronous, active-high
//   load       : load load_value on the next edge (takes priority)
//   load_value : start count
//   expired    : high while the count equals one, which is the last cycle of the window
module mem_arb_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             expired
);

  logic [CNT_W-1:0] count_r;

  // The counter loads on request, otherwise counts down and saturates at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != {CNT_W{1'b0}}) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == CNT_W'(1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-port master for the 16-bit memory bus.
// The instruction-fetch port (read-only) and the data port (read/write)
// issue level-held requests. Each granted request becomes a one-cycle
// mem_read or mem_write strobe. The arbiter waits for mem_ack and then
// returns a one-cycle port ack together with the captured read data.
// All outputs are registered.
//
// Ports:
//   clock, reset                  rising-edge clock, async active-high reset
//   i_req, i_addr                 fetch request and address
//   i_ack, i_data                 fetch completion pulse and fetched word
//   d_req, d_we, d_addr, d_wdata  data request
//   d_ack, d_rdata                data completion pulse and read data
//   bus_err                       set with the ack of an aborted transfer
//   mem_read, mem_write           memory strobes
//   mem_addr, mem_data_out        memory address and write data
//   mem_data_in, mem_ack          memory read data and ack
//
// Optional build macro:
//   MEM_ARB_TIMEOUT_EN  abort a WAIT after TIMEOUT_CYCLES cycles without
//                       mem_ack. Without the macro, WAIT waits indefinitely
//                       and bus_err is tied low.
module mem_bus_arbiter
  import mem_bus_defs::*;
#(
  parameter int ADDR_W         = BUS_ADDR_W,
  parameter int DATA_W         = BUS_DATA_W,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              bus_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_ack
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0] state_r;
  logic       grant_r;   // last granted port; it also owns the transfer in flight
  logic       we_r;      // the transfer in flight is a write
  logic       pick_d_s;

  assign pick_d_s = pick_data_port(i_req, d_req, grant_r);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic timer_load_s;
  logic expired_s;
  logic bus_err_r;

  // The timer is armed during ISSUE, so the count starts fresh on WAIT entry.
  assign timer_load_s = (state_r == ST_ISSUE);

  mem_arb_timer #(
    .CNT_W(TMR_W)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (timer_load_s),
    .load_value(TMR_W'(TIMEOUT_CYCLES)),
    .expired   (expired_s)
  );

  // The abort flag is set together with the port ack of a timed-out transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus_err_r <= 1'b0;
    end else if ((state_r == ST_WAIT) && !mem_ack && expired_s) begin
      bus_err_r <= 1'b1;
    end else if (state_r == ST_DONE) begin
      bus_err_r <= 1'b0;
    end else begin
      bus_err_r <= bus_err_r;
    end
  end

  assign bus_err = bus_err_r;
`else
  assign bus_err = 1'b0;
`endif

  // Arbitration FSM and registered bus/port outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      grant_r      <= PORT_I;
      we_r         <= 1'b0;
      i_ack        <= 1'b0;
      d_ack        <= 1'b0;
      i_data       <= {DATA_W{1'b0}};
      d_rdata      <= {DATA_W{1'b0}};
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
      mem_data_out <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_req || d_req) begin
            state_r <= ST_ISSUE;
            if (pick_d_s) begin
              grant_r      <= PORT_D;
              we_r         <= d_we;
              mem_addr     <= d_addr;
              mem_data_out <= d_wdata;
              mem_read     <= ~d_we;
              mem_write    <= d_we;
            end else begin
              grant_r   <= PORT_I;
              we_r      <= 1'b0;
              mem_addr  <= i_addr;
              mem_read  <= 1'b1;
              mem_write <= 1'b0;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // The strobe lasts exactly one cycle. mem_ack is not sampled here.
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state_r   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_ack) begin
            state_r <= ST_DONE;
            if (grant_r == PORT_D) begin
              d_ack <= 1'b1;
              if (!we_r) begin
                d_rdata <= mem_data_in;
              end
            end else begin
              i_ack  <= 1'b1;
              i_data <= mem_data_in;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (expired_s) begin
            // Abort: the port is released with all-ones read data.
            state_r <= ST_DONE;
            if (grant_r == PORT_D) begin
              d_ack <= 1'b1;
              if (!we_r) begin
                d_rdata <= {DATA_W{1'b1}};
              end
            end else begin
              i_ack  <= 1'b1;
              i_data <= {DATA_W{1'b1}};
            end
          end
`endif
          else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DONE: begin
          // No grant is made here. A request still held high is taken only from IDLE.
          i_ack   <= 1'b0;
          d_ack   <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          i_ack     <= 1'b0;
          d_ack     <= 1'b0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
